if_prefetch_queue: RTL and testbench
====================================

IF_PREFETCH_QUEUE -- requirements
Module: if_prefetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of instruction-queue entries (power of two, minimum 2).
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0040_0000, meaning the first fetch address after reset.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port redirect_valid, input, 1 bit: branch, jump or jr target taken this cycle.
REQ-006 The block SHALL have port redirect_pc, input, 32 bits: the new fetch address.
REQ-007 The block SHALL have port mem_req_valid, output, 1 bit: a fetch request to program memory.
REQ-008 The block SHALL have port mem_req_ready, input, 1 bit: program memory accepts the request.
REQ-009 The block SHALL have port mem_req_addr, output, 32 bits: the fetch address.
REQ-010 The block SHALL have port mem_rsp_valid, input, 1 bit: an instruction word is returned, in order, at least 1 cycle after acceptance.
REQ-011 The block SHALL have port mem_rsp_data, input, 32 bits: the returned instruction.
REQ-012 The block SHALL have port inst_valid, output, 1 bit: the queue head is valid toward the IF/ID register.
REQ-013 The block SHALL have port inst_ready, input, 1 bit: IF/ID accepts the head (low while stalled).
REQ-014 The block SHALL have port inst_data, output, 32 bits: the head instruction.
REQ-015 The block SHALL have port inst_pc_4, output, 32 bits: the head instruction address + 4.
REQ-016 The block SHALL have port queue_count, output, $clog2(DEPTH+1) bits: the number of occupied entries.

Function
REQ-017 A request SHALL be issued (mem_req_valid=1, mem_req_addr=fetch_pc) only in state RUN with outstanding+queue_count < DEPTH and redirect_valid=0.
REQ-018 On request acceptance (valid&ready), fetch_pc SHALL become fetch_pc+4 (32-bit wrap) and outstanding SHALL increment.
REQ-019 Each in-order response in RUN SHALL push {data, addr+4}, decrement outstanding, and never overflow (credit rule REQ-017).
REQ-020 A pop SHALL occur when inst_valid&inst_ready; simultaneous push and pop SHALL leave queue_count unchanged, including when the queue is full.
REQ-021 A redirect SHALL, at the next edge: empty the queue, set fetch_pc=redirect_pc, load drop_cnt=outstanding (minus a response arriving in the same cycle), and enter DRAIN if drop_cnt>0, else RUN.
REQ-022 A response arriving in the redirect cycle SHALL be discarded; a pop in the redirect cycle SHALL complete normally.
REQ-023 In DRAIN, no requests SHALL be issued, each response SHALL be discarded and decrement drop_cnt, and the block SHALL return to RUN when drop_cnt reaches 0.
REQ-024 A redirect during DRAIN SHALL update fetch_pc and keep the pending drop_cnt.
REQ-025 inst_valid SHALL be 0 whenever the queue is empty.
REQ-026 Without bypass, the data/pc outputs SHALL be registered, and a response SHALL appear at inst_valid one cycle later.

Reset
REQ-027 On reset assertion, the block SHALL asynchronously set: state=RUN, fetch_pc=RESET_PC, outstanding=0, drop_cnt=0, queue empty, inst_valid=0, inst_data=0, inst_pc_4=0, queue_count=0, mem_req_valid=0 while reset is high.
REQ-028 A reset mid-operation SHALL abandon in-flight requests; the program-memory model is reset alongside.

Configuration
REQ-029 When IFQ_BYPASS_EN is defined: with the queue empty, state RUN, and no redirect, a response SHALL drive inst_valid/inst_data/inst_pc_4 combinationally in the same cycle and, if inst_ready=1, SHALL not be enqueued.
REQ-030 When IFQ_BYPASS_EN is undefined, the bypass SHALL not exist and latency SHALL follow REQ-026.

Structure
REQ-031 The shared package mips_pkg SHALL hold the ifq_state_t enum (RUN, DRAIN), the RESET_PC default, and the INST_WIDTH=32 constant.
REQ-032 The storage SHALL be one sub-module, ifq_fifo: a synchronous FIFO with push/pop/count and an async reset.

Verification
REQ-033 Verification SHALL cover: reset release, mem_req_ready=1, 1-cycle memory -> requests at 0x00400000, 0x00400004, ...; inst_pc_4=0x00400004 first.
REQ-034 Verification SHALL cover: inst_ready=0 for 10 cycles -> queue_count saturates at 4, mem_req_valid=0, no word lost or duplicated after release.
REQ-035 Verification SHALL cover: redirect to 0x00400100 with 3 outstanding, 3-cycle memory -> 3 responses dropped, state returns to RUN, next delivered inst_pc_4=0x00400104.
REQ-036 Verification SHALL cover: redirect coincident with a response and a pop -> the response is discarded, the pop counts, queue_count=0 the next cycle.
REQ-037 Verification SHALL cover: fetch_pc=0xFFFFFFFC accepted -> next address 0x00000000.
REQ-038 Verification SHALL cover: with IFQ_BYPASS_EN, empty queue and inst_ready=1 -> inst_valid in the response cycle with queue_count=0; without it, one cycle later.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared fetch-stage types and constants: queue state, entry layout, reset PC.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mips_pkg;

  localparam int INST_WIDTH = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

  typedef enum logic {
    RUN,
    DRAIN
  } ifq_state_t;

  typedef struct packed {
    logic [INST_WIDTH-1:0] data;
    logic [INST_WIDTH-1:0] pc_4;
  } ifq_entry_t;

  localparam int IFQ_ENTRY_W = $bits(ifq_entry_t);

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO with flush; the head is read straight from the storage registers.
// Latency: a push is visible at the head one cycle later.
// Backpressure: a push into a full FIFO is taken only when a pop happens in the same cycle.
module ifq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  logic [W-1:0]                 push_entry,
  input  logic                         pop,
  output logic [W-1:0]                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue: credit-limited fetch, in-order responses, redirect with drain. Optional IFQ_BYPASS_EN.
// Latency: response to inst_valid one cycle (same cycle with IFQ_BYPASS_EN and an empty queue).
// Backpressure: inst_ready low fills the queue; requests stop once outstanding+queued reaches DEPTH.
module if_prefetch_queue
  import mips_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic [31:0]                mem_req_addr,
  input  logic                       mem_rsp_valid,
  input  logic [31:0]                mem_rsp_data,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [31:0]                inst_data,
  output logic [31:0]                inst_pc_4,
  output logic [$clog2(DEPTH+1)-1:0] queue_count
);

  localparam int CW = $clog2(DEPTH+1);

  ifq_state_t    state;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] rsp_left;
  logic [CW:0]   credit_used;
  logic          req_fire;
  logic          rsp_run;
  logic          head_valid;
  logic          bypass;
  logic          fifo_push;
  logic          fifo_pop;
  ifq_entry_t    rsp_entry;
  ifq_entry_t    head;

  assign credit_used   = {1'b0, outstanding} + {1'b0, fifo_count};
  assign mem_req_valid = !reset && (state == RUN) && !redirect_valid &&
                         (credit_used < (CW+1)'(DEPTH));
  assign mem_req_addr  = fetch_pc;
  assign req_fire      = mem_req_valid && mem_req_ready;
  assign rsp_run       = mem_rsp_valid && (state == RUN) && !redirect_valid;
  assign rsp_left      = outstanding - CW'(mem_rsp_valid);

  // Responses are in order, so the oldest outstanding address trails fetch_pc by 4*outstanding.
  assign rsp_entry.data = mem_rsp_data;
  assign rsp_entry.pc_4 = fetch_pc - 32'({outstanding, 2'b00}) + 32'd4;

  assign head_valid = (fifo_count != '0);
`ifdef IFQ_BYPASS_EN
  assign bypass = rsp_run && !head_valid;
`else
  assign bypass = 1'b0;
`endif

  assign inst_valid  = head_valid || bypass;
  assign inst_data   = bypass ? rsp_entry.data : head.data;
  assign inst_pc_4   = bypass ? rsp_entry.pc_4 : head.pc_4;
  assign queue_count = fifo_count;
  assign fifo_push   = rsp_run && !(bypass && inst_ready);
  assign fifo_pop    = inst_ready && head_valid;

  ifq_fifo #(
    .DEPTH (DEPTH),
    .W     (IFQ_ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (fifo_push),
    .push_entry (rsp_entry),
    .pop        (fifo_pop),
    .head       (head),
    .count      (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      case (state)
        RUN: begin
          if (redirect_valid) begin
            fetch_pc    <= redirect_pc;
            outstanding <= '0;
            drop_cnt    <= rsp_left;
            state       <= (rsp_left != '0) ? DRAIN : RUN;
          end else begin
            if (req_fire) fetch_pc <= fetch_pc + 32'd4;
            outstanding <= outstanding + CW'(req_fire) - CW'(mem_rsp_valid);
          end
        end
        DRAIN: begin
          if (redirect_valid) fetch_pc <= redirect_pc;
          if (mem_rsp_valid) begin
            drop_cnt <= drop_cnt - CW'(1);
            if (drop_cnt == CW'(1)) state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue with an in-order program-memory model.
module tb_if_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc_4;
  logic [2:0]  queue_count;

  if_prefetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc_4      (inst_pc_4),
    .queue_count    (queue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          lat    = 1;
  int          n;
  int          m;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] req_log[$];
  logic [31:0] got_log[$];
  logic [31:0] exp_pc4;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ~a;
  endfunction

  task automatic settle();
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mem_word(mq_addr[0]);
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
    end
    #1;
  endtask

  task automatic commit();
    int due;
    if (inst_valid && inst_ready) begin
      got_log.push_back(inst_pc_4);
      check("inst_pc_4", inst_pc_4, exp_pc4);
      check("inst_data", inst_data, mem_word(exp_pc4 - 32'd4));
      exp_pc4 = exp_pc4 + 32'd4;
    end
    if (redirect_valid) exp_pc4 = redirect_pc + 32'd4;
    if (mem_rsp_valid) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    if (mem_req_valid && mem_req_ready) begin
      req_log.push_back(mem_req_addr);
      due = cyc + lat;
      if (mq_due.size() > 0 && due <= mq_due[mq_due.size()-1]) due = mq_due[mq_due.size()-1] + 1;
      mq_addr.push_back(mem_req_addr);
      mq_due.push_back(due);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic tick();
    settle();
    commit();
  endtask

  task automatic quiesce(input string tag);
    mem_req_ready = 1'b0;
    inst_ready    = 1'b1;
    for (int i = 0; i < 20 && (mq_addr.size() != 0 || queue_count != 0); i++) tick();
    check({tag, "_cnt"}, 32'(queue_count), 32'd0);
    check({tag, "_mem"}, 32'(mq_addr.size()), 32'd0);
  endtask

  task automatic wait_delivery(input string tag, input int base);
    for (int i = 0; i < 30 && got_log.size() <= base; i++) tick();
    check({tag, "_timeout"}, 32'(got_log.size() > base), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; inst_ready = 1'b0;
    exp_pc4 = RESET_PC + 32'd4;
    @(negedge clk); #1;
    check("rst_req_vld", 32'(mem_req_valid), 32'd0);
    check("rst_inst_vld", 32'(inst_valid), 32'd0);
    check("rst_cnt", 32'(queue_count), 32'd0);
    check("rst_data", inst_data, 32'd0);
    check("rst_pc4", inst_pc_4, 32'd0);
    @(negedge clk);
    reset = 1'b0; mem_req_ready = 1'b1; inst_ready = 1'b1; lat = 1;

    // first fetches and response latency
    settle();
    check("req0_vld", 32'(mem_req_valid), 32'd1);
    check("req0_addr", mem_req_addr, RESET_PC);
    check("c0_inst_vld", 32'(inst_valid), 32'd0);
    commit();
    settle();
    check("rsp_cycle_vld", 32'(inst_valid), 32'(BYP));
    check("rsp_cycle_cnt", 32'(queue_count), 32'd0);
    commit();
    settle();
    check("next_cycle_vld", 32'(inst_valid), 32'd1);
    commit();
    repeat (8) tick();
    check("req_seq1", req_log[1], 32'h0040_0004);
    check("req_seq2", req_log[2], 32'h0040_0008);
    check("first_pc4", got_log[0], 32'h0040_0004);

    // stall saturates the queue, then drains without loss
    inst_ready = 1'b0;
    repeat (10) tick();
    settle();
    check("stall_cnt", 32'(queue_count), 32'd4);
    check("stall_req", 32'(mem_req_valid), 32'd0);
    check("stall_vld", 32'(inst_valid), 32'd1);
    commit();
    n = got_log.size();
    inst_ready = 1'b1;
    repeat (12) tick();
    check("stall_release_pops", 32'(got_log.size() - n), 32'd12);

    // redirect with 3 outstanding on a 3-cycle memory
    quiesce("q3");
    lat = 3; mem_req_ready = 1'b1;
    n = req_log.size();
    repeat (3) tick();
    check("drain_reqs", 32'(req_log.size() - n), 32'd3);
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0100;
    settle();
    check("redir_rsp", 32'(mem_rsp_valid), 32'd1);
    check("redir_req", 32'(mem_req_valid), 32'd0);
    commit();
    redirect_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      settle();
      check("drain_req", 32'(mem_req_valid), 32'd0);
      check("drain_vld", 32'(inst_valid), 32'd0);
      commit();
    end
    settle();
    check("run_req_vld", 32'(mem_req_valid), 32'd1);
    check("run_req_addr", mem_req_addr, 32'h0040_0100);
    commit();
    n = got_log.size();
    wait_delivery("redir", n);
    check("redir_first", got_log[n], 32'h0040_0104);

    // redirect coincident with a response and a pop
    quiesce("q4");
    lat = 1; mem_req_ready = 1'b1; inst_ready = 1'b0;
    repeat (3) tick();
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0040_0200;
    settle();
    check("co_rsp", 32'(mem_rsp_valid), 32'd1);
    check("co_vld", 32'(inst_valid), 32'd1);
    check("co_cnt", 32'(queue_count), 32'd2);
    n = got_log.size();
    commit();
    redirect_valid = 1'b0;
    check("co_pop", 32'(got_log.size() - n), 32'd1);
    settle();
    check("co_cnt_next", 32'(queue_count), 32'd0);
    check("co_vld_next", 32'(inst_valid), 32'd0);
    commit();
    n = got_log.size();
    wait_delivery("co", n);
    check("co_first", got_log[n], 32'h0040_0204);

    // 32-bit wrap of the fetch address
    n = req_log.size();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    m = got_log.size();
    repeat (10) tick();
    check("wrap_req0", req_log[n], 32'hFFFF_FFF8);
    check("wrap_req1", req_log[n+1], 32'hFFFF_FFFC);
    check("wrap_req2", req_log[n+2], 32'h0000_0000);
    check("wrap_pc4_0", got_log[m], 32'hFFFF_FFFC);
    check("wrap_pc4_1", got_log[m+1], 32'h0000_0000);
    check("wrap_pc4_2", got_log[m+2], 32'h0000_0004);

    // reset mid-operation
    settle();
    reset = 1'b1;
    #1;
    check("mid_rst_req", 32'(mem_req_valid), 32'd0);
    check("mid_rst_vld", 32'(inst_valid), 32'd0);
    check("mid_rst_cnt", 32'(queue_count), 32'd0);
    check("mid_rst_data", inst_data, 32'd0);
    mq_addr.delete();
    mq_due.delete();
    exp_pc4 = RESET_PC + 32'd4;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    reset = 1'b0;
    settle();
    check("post_rst_req", 32'(mem_req_valid), 32'd1);
    check("post_rst_addr", mem_req_addr, RESET_PC);
    commit();
    n = got_log.size();
    wait_delivery("post_rst", n);
    check("post_rst_pc4", got_log[n], 32'h0040_0004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
